plot_arbiter: RTL
=================

// Module: plot_arbiter
// PURPOSE
//  Owns the single pixel-write port (x, y, colour, plot) of the VGA adapter and shares it
//  between the four player plot requesters and a full-screen clear sweep.
//  - Grants at most one pixel write per CLOCK_50 cycle, rotating fairly among the players.
//  - Replaces the fixed P1->P4 draw rotation, which issued writes whether or not a player
//    had moved.
// PARAMETERS
//  X_MAX      160     screen width in pixels; valid x is 0..X_MAX-1
//  Y_MAX      120     screen height in pixels; valid y is 0..Y_MAX-1
//  BG_COLOUR  3'b000  colour written by the clear sweep
//  P1_COLOUR  3'b001  colour for player 1 (P2 3'b010, P3 3'b100, P4 3'b110 via P2_/P3_/P4_COLOUR)
// PORTS
//  CLOCK_50    in   1   system clock, 50 MHz
//  resetn      in   1   asynchronous, active-low reset
//  req         in   4   req[i]: player i+1 requests a pixel write (level)
//  p1..p4      in   15  player position, {x[14:7], y[6:0]}; held stable while req[i]=1
//  gnt         out  4   one-hot, one-cycle pulse: request i accepted this cycle
//  clear_req   in   1   pulse or level; starts a full-screen clear from IDLE
//  clear_busy  out  1   high for the whole clear sweep
//  clear_done  out  1   one-cycle pulse, coincident with the last clear pixel
//  x           out  8   pixel x to the VGA adapter
//  y           out  7   pixel y to the VGA adapter
//  colour      out  3   pixel colour to the VGA adapter
//  plot        out  1   write enable to the VGA adapter
// BEHAVIOUR
//  Reset
//  - While resetn=0: x, y, colour, plot, gnt, clear_busy and clear_done are all 0.
//  - FSM goes to IDLE; round-robin pointer goes to P1; clear counters go to 0.
//  - Reset asserted mid-sweep aborts the clear. No clear_done is issued.
//  FSM states
//  - IDLE:  arbitrates player requests every cycle (no separate grant state).
//  - CLEAR: sweeps the screen.
//  IDLE
//  - clear_req=1 takes priority over any player request: enter CLEAR, no grant that cycle.
//  - Otherwise, if any req bit is set, grant the first set bit at or after the pointer,
//    in order P1, P2, P3, P4, wrapping.
//  - Pointer then moves to the player after the granted one.
//  - With all four requests held, grants go 1,2,3,4,1,...
//  Player grant timing and outputs
//  - gnt[i] is a registered pulse in cycle n+1 for req sampled in cycle n.
//  - x, y, colour and plot are registered in the same cycle n+1: x=pos[14:7], y=pos[6:0],
//    colour=Pi_COLOUR, plot=1.
//  - Back-to-back grants on consecutive cycles are allowed.
//  - In cycles with no grant: plot=0, and x/y/colour hold their last values.
//  Handshake
//  - req is level-sensitive. The requester drops req in the cycle after it sees gnt.
//  - If req is still high in that cycle, it is a new request.
//  - While waiting for gnt, the requester holds req and its position stable.
//  Out-of-range positions
//  - A request with x>=X_MAX or y>=Y_MAX is still granted (gnt pulses), but plot=0.
//  CLEAR
//  - One pixel per cycle, row-major: x is the inner loop 0..X_MAX-1, y is the outer loop
//    0..Y_MAX-1; colour=BG_COLOUR, plot=1.
//  - First pixel (0,0) is output in the cycle after entry; the sweep is X_MAX*Y_MAX cycles
//    (19200 with defaults).
//  - clear_busy=1 from the first pixel through the last.
//  - clear_done pulses with pixel (X_MAX-1, Y_MAX-1); the FSM returns to IDLE in the next cycle.
//  - During CLEAR: clear_req is ignored, req is not granted, gnt=0, and requests stay pending.
//  - Pointer is unchanged by a clear.
// CONFIGURATION
//  PLOT_ARB_SKIP_DUP_EN
//  - Defined: one 15-bit last-plotted register per player, cleared by reset and by a
//    completed clear.
//    - A grant whose position equals that player's register produces gnt with plot=0.
//    - Otherwise plot=1 and the register is updated.
//  - Undefined: every in-range grant plots; no registers are instantiated.
// TESTING
//  1. Hold resetn=0, all req=1 -> gnt=0, plot=0, x=0, y=0, colour=0, clear_busy=0 every cycle.
//  2. req=4'b0010, p2={8'd10,7'd20} for 1 cycle -> next cycle gnt=4'b0010,
//     x=10, y=20, colour=3'b010, plot=1; the cycle after, plot=0.
//  3. req=4'b1111 held for 5 cycles -> gnt sequence 0001,0010,0100,1000,0001, with colour
//     001,010,100,110,001.
//  4. clear_req pulse, then req=4'b0001 held -> 19200 plot cycles from (0,0) to (159,119),
//     colour=0, clear_done on the last; gnt=4'b0001 exactly 2 cycles after clear_done.
//  5. resetn=0 for 1 cycle at clear pixel 500 -> outputs 0; after release, IDLE grants
//     req normally and no clear_done is seen.
//  6. p3={8'd200,7'd5} -> gnt=4'b0100, plot=0.
//     With PLOT_ARB_SKIP_DUP_EN, grant p3={8'd7,7'd7} twice -> second grant has plot=0;
//     without the macro -> plot=1 both times.

Source files
------------

// File: rtl/plot_arbiter.sv
// plot_arbiter: owns the VGA pixel-write port and shares it between four
// round-robin player requesters and a full-screen clear sweep.
// Optional feature macro: PLOT_ARB_SKIP_DUP_EN (suppress re-plotting a player's
// last plotted position).
module plot_arbiter #(
    parameter int unsigned X_MAX     = 160,
    parameter int unsigned Y_MAX     = 120,
    parameter logic [2:0]  BG_COLOUR = 3'b000,
    parameter logic [2:0]  P1_COLOUR = 3'b001,
    parameter logic [2:0]  P2_COLOUR = 3'b010,
    parameter logic [2:0]  P3_COLOUR = 3'b100,
    parameter logic [2:0]  P4_COLOUR = 3'b110
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [3:0]  req,
    input  logic [14:0] p1,
    input  logic [14:0] p2,
    input  logic [14:0] p3,
    input  logic [14:0] p4,
    output logic [3:0]  gnt,
    input  logic        clear_req,
    output logic        clear_busy,
    output logic        clear_done,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;
    localparam logic [7:0] X_LAST  = 8'(X_MAX - 1);
    localparam logic [6:0] Y_LAST  = 7'(Y_MAX - 1);

    logic [0:0]  state, state_nxt;
    logic [1:0]  ptr, ptr_nxt;
    logic [7:0]  cx, cx_nxt;
    logic [6:0]  cy, cy_nxt;
    logic [3:0]  gnt_nxt;
    logic [7:0]  x_nxt;
    logic [6:0]  y_nxt;
    logic [2:0]  colour_nxt;
    logic        plot_nxt, busy_nxt, done_nxt;
    logic        emit_clear, found, in_range;
    logic [1:0]  idx, sel;
    logic [14:0] pos;
    logic [2:0]  pcol;

`ifdef PLOT_ARB_SKIP_DUP_EN
    logic [14:0] last_pos     [4];
    logic [14:0] last_pos_nxt [4];
`endif

    // Next-state, arbitration, clear sweep and output computation
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        cx_nxt     = cx;
        cy_nxt     = cy;
        gnt_nxt    = '0;
        x_nxt      = x;
        y_nxt      = y;
        colour_nxt = colour;
        plot_nxt   = 1'b0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        emit_clear = 1'b0;
        found      = 1'b0;
        in_range   = 1'b0;
        idx        = '0;
        sel        = '0;
        pos        = '0;
        pcol       = '0;
`ifdef PLOT_ARB_SKIP_DUP_EN
        for (int i = 0; i < 4; i++) last_pos_nxt[i] = last_pos[i];
`endif
        case (state)
            S_IDLE: begin
                if (clear_req) begin
                    state_nxt  = S_CLEAR;
                    emit_clear = 1'b1;
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        idx = ptr + 2'(k);
                        if (!found && req[idx]) begin
                            found = 1'b1;
                            sel   = idx;
                        end
                    end
                    if (found) begin
                        case (sel)
                            2'd0:    begin pos = p1; pcol = P1_COLOUR; end
                            2'd1:    begin pos = p2; pcol = P2_COLOUR; end
                            2'd2:    begin pos = p3; pcol = P3_COLOUR; end
                            default: begin pos = p4; pcol = P4_COLOUR; end
                        endcase
                        gnt_nxt[sel] = 1'b1;
                        ptr_nxt      = sel + 2'd1;
                        x_nxt        = pos[14:7];
                        y_nxt        = pos[6:0];
                        colour_nxt   = pcol;
                        in_range     = (32'(pos[14:7]) < X_MAX) && (32'(pos[6:0]) < Y_MAX);
                        plot_nxt     = in_range;
`ifdef PLOT_ARB_SKIP_DUP_EN
                        if (in_range) begin
                            if (last_pos[sel] == pos) plot_nxt = 1'b0;
                            else                      last_pos_nxt[sel] = pos;
                        end
`endif
                    end
                end
            end
            default: begin
                // clear_done still high means the last pixel is on the port: leave
                if (clear_done) begin
                    state_nxt = S_IDLE;
`ifdef PLOT_ARB_SKIP_DUP_EN
                    for (int i = 0; i < 4; i++) last_pos_nxt[i] = '0;
`endif
                end else begin
                    emit_clear = 1'b1;
                end
            end
        endcase

        if (emit_clear) begin
            x_nxt      = cx;
            y_nxt      = cy;
            colour_nxt = BG_COLOUR;
            plot_nxt   = 1'b1;
            busy_nxt   = 1'b1;
            if (cx == X_LAST) begin
                cx_nxt = '0;
                if (cy == Y_LAST) begin
                    cy_nxt   = '0;
                    done_nxt = 1'b1;
                end else begin
                    cy_nxt = cy + 7'd1;
                end
            end else begin
                cx_nxt = cx + 8'd1;
            end
        end
    end

    // State, pointer, sweep counters and registered outputs
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            ptr        <= '0;
            cx         <= '0;
            cy         <= '0;
            gnt        <= '0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            cx         <= cx_nxt;
            cy         <= cy_nxt;
            gnt        <= gnt_nxt;
            x          <= x_nxt;
            y          <= y_nxt;
            colour     <= colour_nxt;
            plot       <= plot_nxt;
            clear_busy <= busy_nxt;
            clear_done <= done_nxt;
        end
    end

`ifdef PLOT_ARB_SKIP_DUP_EN
    // Per-player last plotted position
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) last_pos[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) last_pos[i] <= last_pos_nxt[i];
        end
    end
`endif

endmodule
